// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan scheduler for a shared 4-digit common-anode seven-segment display.
// Inputs are snapshotted at each slot boundary and a blanking guard opens every slot.
module seg7_scan_ctrl #(
  parameter int TICK_DIV = 100000,
  parameter int GUARD    = 1000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic [1:0]  scan_idx,
  output logic        slot_tick
);

  localparam logic [16:0] CNT_MAX   = 17'(TICK_DIV - 1);
  localparam logic [16:0] GUARD_CNT = 17'(GUARD);

  logic [16:0] cnt;
  logic [1:0]  idx;
  logic [15:0] val_s;
  logic [3:0]  blank_s;
  logic [3:0]  dp_s;

  logic        wrap;
  logic        z3, z2, z1;
  logic [3:0]  lz;
  logic [3:0]  digit;
  logic        vis;
  logic [6:0]  hex_seg;

  assign wrap     = (cnt == CNT_MAX);
  assign scan_idx = idx;

  // Leading-zero suppression cascades down from the most significant digit.
  always_comb begin
    z3 = (val_s[15:12] == 4'h0);
    z2 = z3 && (val_s[11:8] == 4'h0);
    z1 = z2 && (val_s[7:4] == 4'h0);
    lz = 4'b0000;
    if (LZ_BLANK) lz = {z3, z2, z1, 1'b0};
  end

  assign digit = val_s[{idx, 2'b00} +: 4];
  assign vis   = en & ~blank_s[idx] & ~lz[idx];

  always_comb begin
    hex_seg = 7'h7F;
    case (digit)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      4'hF: hex_seg = 7'h0E;
      default: hex_seg = 7'h7F;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      val_s     <= '0;
      blank_s   <= 4'b1111;
      dp_s      <= '0;
      slot_tick <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'h7F;
      dp_out    <= 1'b1;
    end else begin
      slot_tick <= wrap;
      if (wrap) begin
        cnt     <= '0;
        idx     <= idx + 2'd1;
        val_s   <= value;
        blank_s <= blank;
        dp_s    <= dp;
      end else begin
        cnt <= cnt + 17'd1;
      end
      // Outputs reflect the pre-edge slot state, so they trail cnt/idx by one cycle.
      if ((cnt < GUARD_CNT) || !vis) begin
        an     <= 4'b1111;
        seg    <= 7'h7F;
        dp_out <= 1'b1;
      end else begin
        an     <= ~(4'b0001 << idx);
        seg    <= hex_seg;
        dp_out <= ~dp_s[idx];
      end
    end
  end

endmodule
